// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit in the EX stage (radix-2 shift-add / restoring divide on magnitudes).
// Latency: 33 edges from accept to the o_valid cycle; divide-by-zero, signed overflow and early-out cases take 1.
// Backpressure: o_ready is high only in IDLE; requests seen while busy are ignored and must be held by the requester.
// Optional: define MD_EARLY_OUT_EN to finish zero-operand multiplies and |dividend| < |divisor| divides in IDLE.
module md_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [2:0]        i_md_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    input  logic              i_flush,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_md_data
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    state_t state, state_nxt;

    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q;      // |a|; reused as the quotient shift register when dividing
    logic [DATA_W-1:0]   b_q;      // |b|; shifted right as the multiplier bits are consumed
    logic [2*DATA_W-1:0] acc_q;    // product, or remainder in the upper half when dividing
    logic [CNT_W-1:0]    cnt_q;
    logic                sign_a_q;
    logic                sign_b_q;

    // request decode
    logic              req_div;
    logic              a_signed_pos;
    logic              b_signed_pos;
    logic              req_sign_a;
    logic              req_sign_b;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              early_out;
    logic              special;
    logic [DATA_W-1:0] special_res;
    logic              accept;

    // iteration and fix-up datapath
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_part;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   fix_res;

    assign req_div      = i_md_op[2];
    assign a_signed_pos = (i_md_op == OP_MULH) || (i_md_op == OP_MULHSU) ||
                          (i_md_op == OP_DIV)  || (i_md_op == OP_REM);
    assign b_signed_pos = (i_md_op == OP_MULH) || (i_md_op == OP_DIV) || (i_md_op == OP_REM);
    assign req_sign_a   = a_signed_pos & i_operand_a[DATA_W-1];
    assign req_sign_b   = b_signed_pos & i_operand_b[DATA_W-1];
    assign mag_a        = req_sign_a ? -i_operand_a : i_operand_a;
    assign mag_b        = req_sign_b ? -i_operand_b : i_operand_b;
    assign div_zero     = req_div && (i_operand_b == '0);
    assign div_ovf      = ((i_md_op == OP_DIV) || (i_md_op == OP_REM)) &&
                          (i_operand_a == MIN_NEG) && (i_operand_b == ALL_ONES);
`ifdef MD_EARLY_OUT_EN
    assign early_out    = req_div ? (mag_a < mag_b)
                                  : ((i_operand_a == '0) || (i_operand_b == '0));
`else
    assign early_out    = 1'b0;
`endif
    assign special      = div_zero | div_ovf | early_out;
    assign accept       = (state == IDLE) && i_valid && !i_flush;

    // result for operations resolved at accept time; i_md_op[1] selects remainder for divides
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = i_md_op[1] ? i_operand_a : ALL_ONES;
        else if (div_ovf)
            special_res = i_md_op[1] ? '0 : MIN_NEG;
        else if (req_div)
            special_res = i_md_op[1] ? i_operand_a : '0;
    end

    // one radix-2 step: right-shifting shift-add multiply, 33-bit restoring divide subtract
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (b_q[0] ? a_q : '0)};
        div_part = {acc_q[2*DATA_W-1:DATA_W], a_q[DATA_W-1]};
        div_diff = div_part - {1'b0, b_q};
        // partial remainder never reaches 2*|b|, so the borrow bit alone decides the quotient bit
        div_ge   = !div_diff[DATA_W];
    end

    // sign correction and result selection for the FIX state
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
        rem_fix  = sign_a_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'd0)
            fix_res = prod_fix[DATA_W-1:0];
        else
            fix_res = prod_fix[2*DATA_W-1:DATA_W];
    end

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake outputs; flush wins over everything and hides the DONE pulse
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (accept)
                    state_nxt = special ? DONE : CALC;
            end
            CALC: begin
                if (i_flush)
                    state_nxt = IDLE;
                else if (cnt_q == CNT_LAST)
                    state_nxt = FIX;
            end
            FIX: begin
                state_nxt = i_flush ? IDLE : DONE;
            end
            DONE: begin
                o_valid   = !i_flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture, iteration registers and the held result
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            o_md_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= i_md_op;
                        a_q      <= mag_a;
                        b_q      <= mag_b;
                        sign_a_q <= req_sign_a;
                        sign_b_q <= req_sign_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        if (special)
                            o_md_data <= special_res;
                    end
                end
                CALC: begin
                    if (!i_flush) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (op_q[2]) begin
                            acc_q[2*DATA_W-1:DATA_W] <= div_ge ? div_diff[DATA_W-1:0]
                                                               : div_part[DATA_W-1:0];
                            a_q <= {a_q[DATA_W-2:0], div_ge};
                        end else begin
                            acc_q <= {mul_sum, acc_q[DATA_W-1:1]};
                            b_q   <= {1'b0, b_q[DATA_W-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!i_flush)
                        o_md_data <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, beside the integer ALU.
- Consumes the same ID/EX operands as the ALU.
- Its result is muxed with the ALU result into the EX/MEM register.
- Multi-cycle: the hazard/stall logic holds IF/ID/EX while it is busy (no forwarding in this pipeline).

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(DATA_W).

Ports:
- i_clk  input  1  clock, rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  request strobe; sampled only when o_ready=1.
- i_md_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_operand_a  input  32  rs1 value (dividend / multiplicand).
- i_operand_b  input  32  rs2 value (divisor / multiplier).
- i_flush  input  1  kill in-flight operation (branch/jump flush).
- o_ready  output  1  high in IDLE; unit accepts a request.
- o_valid  output  1  one-cycle pulse; o_md_data is valid.
- o_md_data  output  32  result; held until the next accepted request.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-high, ports i_clk / i_reset.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_md_data=0, counter=0, internal registers=0.
- Reset mid-operation aborts immediately; no o_valid follows.

State machine (IDLE, CALC, FIX, DONE):
- IDLE:
  - i_valid=1 at edge t0 latches op and operands, and latches the sign flags for the op.
  - Latches |a| and |b| for signed operand positions: MULH both, MULHSU a only, DIV/REM both.
  - Clears the 64-bit accumulator and sets counter=0.
  - Next state is CALC, or DONE for special cases (below).
- CALC: one radix-2 iteration per edge; counter increments. At the edge with counter=31 the last iteration runs and the state moves to FIX.
  - Multiply: shift-add on magnitudes, 64-bit unsigned product.
  - Divide: restoring shift-subtract on magnitudes, giving unsigned quotient and remainder.
- FIX: sign correction and result selection, written into the o_md_data register; next state DONE.
  - Product is negated if the operand signs differ (only signed operands count).
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - MUL selects the low word; MULH/MULHSU/MULHU select the high word; DIV/DIVU quotient; REM/REMU remainder.
- DONE: o_valid=1 for exactly one cycle; next edge goes to IDLE.

Latency and handshake:
- Normal latency: o_valid is high in the cycle after edge t0+33 (t0 = accept edge).
- o_ready=0 from t0 until the return to IDLE.
- i_valid while o_ready=0 is ignored; the requester holds its request (stalled stage).
- A new request may be accepted in the same cycle that o_ready returns high.

Special cases (resolved in IDLE at accept; latency 1; o_valid in the cycle after t0):
- Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.

Flush:
- i_flush=1 in CALC/FIX/DONE: next edge goes to IDLE, o_valid is suppressed that cycle, o_md_data is unchanged.
- i_flush takes priority over i_valid in IDLE: the request is not accepted.

Arithmetic:
- All internal arithmetic is unsigned on magnitudes, 33-bit for the divide subtract.
- Negation is two's complement; wrap-around is modulo 2^32 (2^64 for the product).

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined:
  - Multiply with either operand zero completes in IDLE with latency 1 and result 0.
  - Divide where |dividend| < |divisor| completes with latency 1: quotient 0, remainder = dividend.
- Undefined: these cases take the normal 33-cycle path; the results are identical.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> o_md_data=0xFFFFFFEB; o_valid exactly 33 cycles after accept; o_ready low throughout.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, latency 1; REMU a=0x1234, b=0 -> 0x1234, latency 1; DIVU b=0 -> 0xFFFFFFFF.
- Start DIVU; assert i_flush at cycle 10 -> IDLE next edge, no o_valid, o_md_data unchanged; then issue REM 9/4 -> 1 at normal latency.
- Assert i_reset asynchronously mid-CALC -> o_ready=1, o_valid=0, o_md_data=0 immediately.
- Assert i_valid while busy -> ignored.
- With MD_EARLY_OUT_EN: MUL b=0 and DIVU 3/5 -> latency 1. Without it -> latency 33; results identical.
